stack_pointer_unit: RTL and testbench

- Registered stack-pointer engine for the memory stage. Replaces the single-word combinational SP update.
- Accepts PUSH/POP requests of 1..MAX_BURST words, e.g. a 2-word CALL/RET of a split PC.
- Emits one memory beat per word with the correct address and updates SP beat by beat.
- Stalls with the memory stage and optionally traps stack overflow/underflow.

---
 rtl/stack_pointer_unit.sv | 159 +++++++++++++++
 tb/tb_stack_pointer_unit.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_pointer_unit.sv
`default_nettype none
// ============================================================================
// Module      : stack_pointer_unit
// Description : Registered stack-pointer engine for the memory stage. Accepts
//               PUSH/POP bursts of 1..MAX_BURST words and emits one memory
//               beat per word, updating SP as each beat completes.
//               Optional macro SP_BOUNDS_CHECK_EN enables overflow/underflow
//               trapping with sticky exception flags.
// Revision    : 1.0 - initial release
// ============================================================================
module stack_pointer_unit #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] SP_INIT     = 32'h000F_FFFF,
    parameter logic [ADDR_WIDTH-1:0] STACK_LIMIT = 32'h000F_FF00,
    parameter int                    MAX_BURST   = 2,
    localparam int                   LEN_W       = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  op_valid,
    input  logic                  op_push,
    input  logic [LEN_W-1:0]      op_len,
    output logic                  op_ready,
    input  logic                  stall,
    output logic                  mem_valid,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [LEN_W-1:0]      beat_idx,
    output logic                  beat_last,
    output logic [ADDR_WIDTH-1:0] sp,
    input  logic                  exc_clear,
    output logic                  exc_overflow,
    output logic                  exc_underflow
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_dir_push;
    logic [LEN_W-1:0]      r_len;
    logic [LEN_W-1:0]      r_beat_idx;
    logic [ADDR_WIDTH-1:0] r_sp;

    logic [LEN_W-1:0]      w_len_clamp;
    logic                  w_accept;
    logic                  w_len_nz;
    logic                  w_legal;
    logic                  w_start;
    logic                  w_beat_done;
    logic                  w_last;

    assign w_len_clamp = (op_len > LEN_W'(MAX_BURST)) ? LEN_W'(MAX_BURST) : op_len;
    assign w_accept    = op_valid && (r_state == S_IDLE);
    assign w_len_nz    = (w_len_clamp != '0);
    assign w_start     = w_accept && w_len_nz && w_legal;
    assign w_beat_done = (r_state == S_BURST) && !stall;
    assign w_last      = (r_beat_idx == (r_len - LEN_W'(1)));

`ifdef SP_BOUNDS_CHECK_EN
    // Widened operands; the push test is rearranged to sp+1 >= limit+len so
    // no intermediate value can borrow below zero.
    logic [ADDR_WIDTH:0] w_sp_ext;
    logic [ADDR_WIDTH:0] w_len_ext;
    logic                r_exc_ovf;
    logic                r_exc_unf;
    logic                w_ovf_set;
    logic                w_unf_set;

    assign w_sp_ext  = {1'b0, r_sp};
    assign w_len_ext = (ADDR_WIDTH+1)'(w_len_clamp);
    assign w_legal   = op_push
                     ? ((w_sp_ext + (ADDR_WIDTH+1)'(1)) >= ({1'b0, STACK_LIMIT} + w_len_ext))
                     : ((w_sp_ext + w_len_ext) <= {1'b0, SP_INIT});
    assign w_ovf_set = w_accept && w_len_nz && !w_legal && op_push;
    assign w_unf_set = w_accept && w_len_nz && !w_legal && !op_push;

    // Sticky exception flags; a new exception wins over a same-cycle clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_exc_ovf <= 1'b0;
            r_exc_unf <= 1'b0;
        end else begin
            if (exc_clear) begin
                r_exc_ovf <= 1'b0;
                r_exc_unf <= 1'b0;
            end
            if (w_ovf_set) r_exc_ovf <= 1'b1;
            if (w_unf_set) r_exc_unf <= 1'b1;
        end
    end

    assign exc_overflow  = r_exc_ovf;
    assign exc_underflow = r_exc_unf;
`else
    logic w_unused;

    assign w_legal       = 1'b1;
    assign exc_overflow  = 1'b0;
    assign exc_underflow = 1'b0;
    assign w_unused      = ^{exc_clear, STACK_LIMIT};
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state and beat outputs; mem_addr derives from registered SP so the
    // address and SP can never disagree within a cycle
    always_comb begin
        w_state_nxt = r_state;
        op_ready    = 1'b0;
        mem_valid   = 1'b0;
        mem_write   = 1'b0;
        mem_addr    = '0;
        beat_last   = 1'b0;
        case (r_state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (w_start) w_state_nxt = S_BURST;
            end
            S_BURST: begin
                mem_valid = 1'b1;
                mem_write = r_dir_push;
                mem_addr  = r_dir_push ? r_sp : (r_sp + ADDR_WIDTH'(1));
                beat_last = w_last;
                if (w_beat_done && w_last) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Burst bookkeeping and SP update, one step per completed beat
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp       <= SP_INIT;
            r_dir_push <= 1'b0;
            r_len      <= '0;
            r_beat_idx <= '0;
        end else if (w_start) begin
            r_dir_push <= op_push;
            r_len      <= w_len_clamp;
            r_beat_idx <= '0;
        end else if (w_beat_done) begin
            r_sp       <= r_dir_push ? (r_sp - ADDR_WIDTH'(1)) : (r_sp + ADDR_WIDTH'(1));
            r_beat_idx <= w_last ? '0 : (r_beat_idx + LEN_W'(1));
        end
    end

    assign beat_idx = r_beat_idx;
    assign sp       = r_sp;

endmodule
`default_nettype wire

// File: tb/tb_stack_pointer_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_stack_pointer_unit
// Description : Directed self-checking bench for stack_pointer_unit. Expected
//               beats are queued when a request is issued and compared as the
//               DUT presents them. Honours SP_BOUNDS_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_pointer_unit;

    localparam logic [31:0] SPI = 32'h000F_FFFF;
    localparam logic [31:0] LIM = 32'h000F_FF00;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_push = 1'b0;
    logic [1:0]  op_len = 2'd0;
    logic        op_ready;
    logic        stall = 1'b0;
    logic        mem_valid;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [1:0]  beat_idx;
    logic        beat_last;
    logic [31:0] sp;
    logic        exc_clear = 1'b0;
    logic        exc_overflow;
    logic        exc_underflow;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  idx;
        logic        last;
    } beat_t;

    beat_t       q[$];
    logic [31:0] model_sp = SPI;
    logic        exp_ovf = 1'b0;
    logic        exp_unf = 1'b0;

    stack_pointer_unit dut (
        .clk           (clk),
        .rst           (rst),
        .op_valid      (op_valid),
        .op_push       (op_push),
        .op_len        (op_len),
        .op_ready      (op_ready),
        .stall         (stall),
        .mem_valid     (mem_valid),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .beat_idx      (beat_idx),
        .beat_last     (beat_last),
        .sp            (sp),
        .exc_clear     (exc_clear),
        .exc_overflow  (exc_overflow),
        .exc_underflow (exc_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic p, input logic [1:0] l, input logic clr);
        op_valid  = 1'b1;
        op_push   = p;
        op_len    = l;
        exc_clear = clr;
        tick();
        op_valid  = 1'b0;
        exc_clear = 1'b0;
    endtask

    // Queue the beats a request should produce, then issue it
    task automatic do_op(input logic p, input logic [1:0] l, input logic clr);
        int   n;
        logic legal;
`ifdef SP_BOUNDS_CHECK_EN
        longint s;
`endif
        n = (l > 2'd2) ? 2 : int'(l);
        legal = 1'b1;
        if (clr) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end
`ifdef SP_BOUNDS_CHECK_EN
        s = longint'(model_sp);
        if (n != 0) begin
            if (p) legal = ((s - longint'(n) + 1) >= longint'(LIM));
            else   legal = ((s + longint'(n)) <= longint'(SPI));
            if (!legal) begin
                if (p) exp_ovf = 1'b1;
                else   exp_unf = 1'b1;
            end
        end
`endif
        if (legal) begin
            for (int i = 0; i < n; i++) begin
                beat_t b;
                b.wr   = p;
                b.addr = p ? (model_sp - 32'(i)) : (model_sp + 32'(i + 1));
                b.idx  = 2'(i);
                b.last = (i == n - 1);
                q.push_back(b);
            end
        end
        send(p, l, clr);
    endtask

    // Compare presented beats against the queue; stall the first nstall cycles
    task automatic drain(input int nstall, input logic hold);
        int n;
        n = 0;
        if (hold) begin
            op_valid = 1'b1;
            op_push  = 1'b1;
            op_len   = 2'd1;
        end
        while ((q.size() != 0 || mem_valid) && n < 40) begin
            stall = (n < nstall);
            if (mem_valid) begin
                if (q.size() == 0) begin
                    chk("extra_beat", 32'(mem_valid), 32'd0);
                end else begin
                    chk("beat_write", 32'(mem_write), 32'(q[0].wr));
                    chk("beat_addr",  mem_addr, q[0].addr);
                    chk("beat_idx",   32'(beat_idx), 32'(q[0].idx));
                    chk("beat_last",  32'(beat_last), 32'(q[0].last));
                    chk("beat_sp",    sp, model_sp);
                    if (!stall) begin
                        model_sp = q[0].wr ? (model_sp - 32'd1) : (model_sp + 32'd1);
                        void'(q.pop_front());
                    end
                end
            end
            if (hold) op_valid = (q.size() != 0);
            tick();
            n++;
        end
        stall    = 1'b0;
        op_valid = 1'b0;
        if (n >= 40) begin
            checks++;
            failures++;
            $error("FAIL drain_timeout observed=%0d cycles expected<40", n);
        end
    endtask

    task automatic post(input string tag);
        chk({tag, "_op_ready"}, 32'(op_ready), 32'd1);
        chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
        chk({tag, "_sp"}, sp, model_sp);
        chk({tag, "_exc_ovf"}, 32'(exc_overflow), 32'(exp_ovf));
        chk({tag, "_exc_unf"}, 32'(exc_underflow), 32'(exp_unf));
    endtask

    initial begin
        int n;
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_sp", sp, SPI);
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_mem_valid", 32'(mem_valid), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_beat_idx", 32'(beat_idx), 32'd0);
        chk("rst_beat_last", 32'(beat_last), 32'd0);
        chk("rst_exc_ovf", 32'(exc_overflow), 32'd0);
        chk("rst_exc_unf", 32'(exc_underflow), 32'd0);

        // Single push, then single pop back to the top
        do_op(1'b1, 2'd1, 1'b0);
        chk("push1_latency", 32'(mem_valid), 32'd1);
        drain(0, 1'b0);
        post("push1");
        chk("push1_sp_value", sp, 32'h000F_FFFE);
        do_op(1'b0, 2'd1, 1'b0);
        drain(0, 1'b0);
        post("pop1");

        // Two-word push then two-word pop; op_valid held during the pop burst
        do_op(1'b1, 2'd2, 1'b0);
        drain(0, 1'b0);
        post("push2");
        chk("push2_sp_value", sp, 32'h000F_FFFD);
        do_op(1'b0, 2'd2, 1'b0);
        drain(0, 1'b1);
        post("pop2_hold");
        chk("pop2_sp_value", sp, SPI);

        // Two-word push with beat 0 stalled for three cycles
        do_op(1'b1, 2'd2, 1'b0);
        drain(3, 1'b0);
        post("push2_stall");
        chk("stall_sp_value", sp, 32'h000F_FFFD);

        // Over-length requests clamp to MAX_BURST
        do_op(1'b1, 2'd3, 1'b0);
        drain(0, 1'b0);
        post("push3_clamp");
        do_op(1'b0, 2'd3, 1'b0);
        drain(0, 1'b0);
        post("pop3_clamp");
        do_op(1'b0, 2'd2, 1'b0);
        drain(0, 1'b0);
        post("pop2_top");

        // Zero-length request: accepted, no beats
        do_op(1'b1, 2'd0, 1'b0);
        chk("len0_mem_valid", 32'(mem_valid), 32'd0);
        drain(0, 1'b0);
        post("len0");

        // Pop at top of stack: underflow trap, or a wrapping-free beat
        do_op(1'b0, 2'd1, 1'b0);
        drain(0, 1'b0);
        post("pop_top");
        tick();
        chk("unf_sticky", 32'(exc_underflow), 32'(exp_unf));
        exc_clear = 1'b1;
        tick();
        exc_clear = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        chk("unf_cleared", 32'(exc_underflow), 32'd0);
        if (model_sp != SPI) begin
            do_op(1'b1, 2'd1, 1'b0);
            drain(0, 1'b0);
            post("restore_top");
        end

        // Walk SP down to the stack limit
        for (int k = 0; k < 128; k++) begin
            send(1'b1, (k == 127) ? 2'd1 : 2'd2, 1'b0);
            n = 0;
            while (!op_ready && n < 10) begin
                tick();
                n++;
            end
            if (n >= 10) begin
                checks++;
                failures++;
                $error("FAIL walk_timeout observed=%0d cycles expected<10", n);
            end
        end
        model_sp = LIM;
        chk("walk_sp", sp, LIM);

        // Two-word push at the limit: overflow trap, or beats below the limit
        do_op(1'b1, 2'd2, 1'b0);
        drain(0, 1'b0);
        post("push_limit");

        // Same-cycle clear and new request: a new exception wins
        do_op(1'b1, 2'd2, 1'b1);
        drain(0, 1'b0);
        post("clear_vs_set");

        // Reset in the middle of a two-word pop
        do_op(1'b0, 2'd2, 1'b0);
        chk("rstmid_beat0_valid", 32'(mem_valid), 32'd1);
        chk("rstmid_beat0_addr", mem_addr, model_sp + 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        model_sp = SPI;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        post("rstmid");
        tick();
        chk("rstmid_no_beat1", 32'(mem_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
